// File: rtl/add_reservation_station.sv
// Add/sub/and/or reservation station: issue, CDB capture/wakeup, 1-cycle registered dispatch held until alu_ready.
// Define RS_OLDEST_FIRST_EN to dispatch the oldest ready entry instead of the lowest-index one.
module add_reservation_station #(
  parameter int DEPTH    = 3,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 3,
  parameter int TAG_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [1:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic              isFull,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [TAG_W-1:0]  alu_tag
);
  localparam int IDX_W = 3;

  logic [DEPTH-1:0]  busy_q, busy_d, sent_q, sent_d;
  logic [1:0]        op_q [DEPTH];
  logic [1:0]        op_d [DEPTH];
  logic [DATA_W-1:0] vj_q [DEPTH];
  logic [DATA_W-1:0] vj_d [DEPTH];
  logic [DATA_W-1:0] vk_q [DEPTH];
  logic [DATA_W-1:0] vk_d [DEPTH];
  logic [TAG_W-1:0]  qj_q [DEPTH];
  logic [TAG_W-1:0]  qj_d [DEPTH];
  logic [TAG_W-1:0]  qk_q [DEPTH];
  logic [TAG_W-1:0]  qk_d [DEPTH];

  logic              alu_valid_q, alu_valid_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [TAG_W-1:0]  alu_tag_q, alu_tag_d;

  logic [IDX_W-1:0]  free_idx, sel_idx;
  logic              free_found, sel_vld;
  logic [DEPTH-1:0]  ready, free_hit;
  logic              accept, load, do_issue, cdb_hit;

  assign isFull    = &busy_q;
  assign issue_tag = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
  assign accept    = alu_valid_q & alu_ready;
  assign load      = sel_vld & (~alu_valid_q | alu_ready);
  assign do_issue  = issue_en & ~isFull;
  // Tag 0 means "value present", so a zero-tag broadcast must never match.
  assign cdb_hit   = cdb_valid & (cdb_tag != '0);

  assign alu_valid = alu_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_tag   = alu_tag_q;

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i]    = busy_q[i] & ~sent_q[i] & (qj_q[i] == '0) & (qk_q[i] == '0);
      free_hit[i] = accept & (alu_tag_q == TAG_W'(TAG_BASE + i));
      if (!busy_q[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // age_q counts how many live entries are older; unique among busy entries.
  logic [IDX_W-1:0] age_q [DEPTH];
  logic [IDX_W-1:0] age_d [DEPTH];
  logic [IDX_W-1:0] freed_age, live_cnt, best_age;

  always_comb begin
    freed_age = '0;
    live_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_hit[i]) freed_age = age_q[i];
      if (busy_q[i] && !free_hit[i]) live_cnt = live_cnt + IDX_W'(1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (accept && busy_q[i] && !free_hit[i] && age_q[i] > freed_age)
        age_d[i] = age_q[i] - IDX_W'(1);
      if (do_issue && free_idx == IDX_W'(i))
        age_d[i] = live_cnt;
    end
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_vld || age_q[i] < best_age)) begin
        sel_vld  = 1'b1;
        sel_idx  = IDX_W'(i);
        best_age = age_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) age_q[i] <= rst ? '0 : age_d[i];
  end
`else
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !sel_vld) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    busy_d      = busy_q;
    sent_d      = sent_q;
    op_d        = op_q;
    vj_d        = vj_q;
    qj_d        = qj_q;
    vk_d        = vk_q;
    qk_d        = qk_q;
    alu_valid_d = alu_valid_q & ~accept;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_tag_d   = alu_tag_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && cdb_hit && qj_q[i] == cdb_tag) begin
        vj_d[i] = cdb_data;
        qj_d[i] = '0;
      end
      if (busy_q[i] && cdb_hit && qk_q[i] == cdb_tag) begin
        vk_d[i] = cdb_data;
        qk_d[i] = '0;
      end
      if (free_hit[i]) begin
        busy_d[i] = 1'b0;
        sent_d[i] = 1'b0;
      end
      if (load && sel_idx == IDX_W'(i)) begin
        alu_valid_d = 1'b1;
        alu_op_d    = op_q[i];
        alu_a_d     = vj_q[i];
        alu_b_d     = vk_q[i];
        alu_tag_d   = TAG_W'(TAG_BASE + i);
        sent_d[i]   = 1'b1;
      end
      // The issue slot is never busy, so it cannot collide with wakeup, free or load above.
      if (do_issue && free_idx == IDX_W'(i)) begin
        busy_d[i] = 1'b1;
        sent_d[i] = 1'b0;
        op_d[i]   = issue_op;
        vj_d[i]   = (cdb_hit && issue_qj == cdb_tag) ? cdb_data : issue_vj;
        qj_d[i]   = (cdb_hit && issue_qj == cdb_tag) ? '0 : issue_qj;
        vk_d[i]   = (cdb_hit && issue_qk == cdb_tag) ? cdb_data : issue_vk;
        qk_d[i]   = (cdb_hit && issue_qk == cdb_tag) ? '0 : issue_qk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      sent_q      <= '0;
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_tag_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        qj_q[i] <= '0;
        vk_q[i] <= '0;
        qk_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      sent_q      <= sent_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_tag_q   <= alu_tag_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      qj_q        <= qj_d;
      vk_q        <= vk_d;
      qk_q        <= qk_d;
    end
  end
endmodule

// File: tb/tb_add_reservation_station.sv
// Directed bench for add_reservation_station: issue, full, CDB wakeup/capture, stall, dispatch order, reset.
module tb_add_reservation_station;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_en;
  logic [1:0]        issue_op;
  logic [DATA_W-1:0] issue_vj, issue_vk;
  logic [TAG_W-1:0]  issue_qj, issue_qk;
  logic              isFull;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [TAG_W-1:0]  alu_tag;

  int checks   = 0;
  int failures = 0;

  add_reservation_station dut (
    .clk(clk), .rst(rst),
    .issue_en(issue_en), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_qj(issue_qj),
    .issue_vk(issue_vk), .issue_qk(issue_qk),
    .isFull(isFull), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_tag(alu_tag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] vj, input logic [2:0] qj,
                       input logic [31:0] vk, input logic [2:0] qk);
    issue_en = 1'b1;
    issue_op = op;
    issue_vj = vj;
    issue_qj = qj;
    issue_vk = vk;
    issue_qk = qk;
  endtask

  task automatic cdb(input logic v, input logic [2:0] t, input logic [31:0] d);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] t, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    chk({tag, "_valid"}, 32'(alu_valid), 32'd1);
    chk({tag, "_tag"}, 32'(alu_tag), 32'(t));
    chk({tag, "_op"}, 32'(alu_op), 32'(op));
    chk({tag, "_a"}, alu_a, a);
    chk({tag, "_b"}, alu_b, b);
  endtask

  initial begin
    rst = 1'b1; issue_en = 1'b0; issue_op = '0; issue_vj = '0; issue_qj = '0;
    issue_vk = '0; issue_qk = '0; alu_ready = 1'b0;
    cdb(1'b0, 3'd0, 32'd0);
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 32'(alu_valid), 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    chk("rst_tag", 32'(alu_tag), 32'd0);
    chk("rst_full", 32'(isFull), 32'd0);
    chk("rst_issue_tag", 32'(issue_tag), 32'd1);

    // 1: ready issue dispatches one cycle later, then frees on accept
    issue(2'd0, 32'd5, 3'd0, 32'd7, 3'd0);
    step();
    issue_en = 1'b0;
    chk("t1_not_yet", 32'(alu_valid), 32'd0);
    chk("t1_issue_tag", 32'(issue_tag), 32'd2);
    step();
    chk_out("t1_disp", 3'd1, 2'd0, 32'd5, 32'd7);
    alu_ready = 1'b1;
    step();
    chk("t1_drop", 32'(alu_valid), 32'd0);
    chk("t1_freed", 32'(issue_tag), 32'd1);
    alu_ready = 1'b0;

    // 2: fill, ignored 4th issue, accept frees a slot
    issue(2'd1, 32'd1, 3'd0, 32'd2, 3'd0);
    step();
    issue(2'd2, 32'd3, 3'd0, 32'd4, 3'd0);
    step();
    issue(2'd3, 32'd5, 3'd0, 32'd6, 3'd0);
    step();
    chk("t2_full", 32'(isFull), 32'd1);
    chk_out("t2_hold0", 3'd1, 2'd1, 32'd1, 32'd2);
    issue(2'd0, 32'h99, 3'd0, 32'h99, 3'd0);
    step();
    issue_en = 1'b0;
    chk("t2_still_full", 32'(isFull), 32'd1);
    chk_out("t2_hold1", 3'd1, 2'd1, 32'd1, 32'd2);
    alu_ready = 1'b1;
    step();
    chk("t2_not_full", 32'(isFull), 32'd0);
    chk("t2_issue_tag", 32'(issue_tag), 32'd1);
    chk_out("t2_b2b1", 3'd2, 2'd2, 32'd3, 32'd4);
    step();
    chk_out("t2_b2b2", 3'd3, 2'd3, 32'd5, 32'd6);
    step();
    chk("t2_no_4th", 32'(alu_valid), 32'd0);
    alu_ready = 1'b0;

    // 3: wait on tag 2; foreign and zero-tag broadcasts must be ignored
    issue(2'd1, 32'd0, 3'd2, 32'h20, 3'd0);
    step();
    issue_en = 1'b0;
    cdb(1'b1, 3'd5, 32'hBAD);
    step();
    chk("t3_wait_a", 32'(alu_valid), 32'd0);
    cdb(1'b1, 3'd0, 32'hBAD);
    step();
    chk("t3_wait_b", 32'(alu_valid), 32'd0);
    cdb(1'b1, 3'd2, 32'h10);
    step();
    cdb(1'b0, 3'd0, 32'd0);
    chk("t3_wait_c", 32'(alu_valid), 32'd0);
    step();
    chk_out("t3_wake", 3'd1, 2'd1, 32'h10, 32'h20);
    alu_ready = 1'b1;
    step();
    chk("t3_drop", 32'(alu_valid), 32'd0);
    alu_ready = 1'b0;

    // 4: same-cycle capture of qk
    issue(2'd2, 32'd4, 3'd0, 32'd0, 3'd3);
    cdb(1'b1, 3'd3, 32'd9);
    step();
    issue_en = 1'b0;
    cdb(1'b0, 3'd0, 32'd0);
    chk("t4_not_yet", 32'(alu_valid), 32'd0);
    step();
    chk_out("t4_cap", 3'd1, 2'd2, 32'd4, 32'd9);
    alu_ready = 1'b1;
    step();
    chk("t4_drop", 32'(alu_valid), 32'd0);
    alu_ready = 1'b0;

    // 5: stall stability then back-to-back release
    issue(2'd1, 32'h11, 3'd0, 32'h12, 3'd0);
    step();
    issue(2'd2, 32'h21, 3'd0, 32'h22, 3'd0);
    step();
    issue_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("t5_stall%0d", i), 3'd1, 2'd1, 32'h11, 32'h12);
    end
    alu_ready = 1'b1;
    step();
    chk_out("t5_b2b", 3'd2, 2'd2, 32'h21, 32'h22);
    step();
    chk("t5_drop", 32'(alu_valid), 32'd0);
    alu_ready = 1'b0;

    // 6: older entry in slot 1 vs younger re-issue in slot 0, both ready together
    issue(2'd0, 32'd1, 3'd0, 32'd2, 3'd0);
    step();
    issue(2'd1, 32'd0, 3'd5, 32'h32, 3'd0);
    step();
    issue_en = 1'b0;
    alu_ready = 1'b1;
    step();
    chk("t6_w_gone", 32'(alu_valid), 32'd0);
    chk("t6_slot0_free", 32'(issue_tag), 32'd1);
    alu_ready = 1'b0;
    issue(2'd2, 32'h51, 3'd0, 32'h52, 3'd0);
    cdb(1'b1, 3'd5, 32'h31);
    step();
    issue_en = 1'b0;
    cdb(1'b0, 3'd0, 32'd0);
    step();
`ifdef RS_OLDEST_FIRST_EN
    chk_out("t6_first", 3'd2, 2'd1, 32'h31, 32'h32);
    alu_ready = 1'b1;
    step();
    chk_out("t6_second", 3'd1, 2'd2, 32'h51, 32'h52);
`else
    chk_out("t6_first", 3'd1, 2'd2, 32'h51, 32'h52);
    alu_ready = 1'b1;
    step();
    chk_out("t6_second", 3'd2, 2'd1, 32'h31, 32'h32);
`endif
    step();
    chk("t6_drop", 32'(alu_valid), 32'd0);
    alu_ready = 1'b0;

    // reset mid-operation clears the output register and entries
    issue(2'd3, 32'hA, 3'd0, 32'hB, 3'd0);
    step();
    issue_en = 1'b0;
    step();
    chk("rst2_pre", 32'(alu_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_valid", 32'(alu_valid), 32'd0);
    chk("rst2_a", alu_a, 32'd0);
    chk("rst2_tag", 32'(alu_tag), 32'd0);
    chk("rst2_issue_tag", 32'(issue_tag), 32'd1);
    step();
    chk("rst2_no_disp", 32'(alu_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
